// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Down-counting m:ss timer. A start time is loaded as BCD digits, then the
// value drops by 'subtractor' seconds on every clock while 'count' is high,
// saturating at 0:00. Expiry produces a one-cycle 'done' pulse. The digit
// outputs share the elapsed-time Timer's format and feed driver7seg directly.
//
// Build option: COUNTDOWN_AUTORELOAD_EN
//   defined   - on expiry, reload the last clamped load value and keep running
//   undefined - stop in DONE holding 0:00
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   count        level enable for decrementing
//   load         one-cycle load strobe (wins over count)
//   minutes0_in  BCD minutes to load        (clamped to MAX_MIN)
//   seconds1_in  BCD tens of seconds        (clamped to 5)
//   seconds0_in  BCD units of seconds       (clamped to 9)
//   subtractor   seconds removed per enabled cycle
//   minutes0     minutes digit   (6 bits, upper bits 0)
//   seconds1     tens digit      (6 bits, upper bits 0)
//   seconds0     units digit     (6 bits, upper bits 0)
//   running      high in RUN
//   zero         high when the displayed value is 0:00
//   done         one-cycle expiry pulse
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | reset / empty load, value 0:00
// S_ARMED | value loaded, waiting for count
// S_RUN   | counting (holds while count is low)
// S_DONE  | expired, holds 0:00 until load or reset
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int MAX_MIN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic       load,
    input  logic [3:0] minutes0_in,
    input  logic [3:0] seconds1_in,
    input  logic [3:0] seconds0_in,
    input  logic [5:0] subtractor,
    output logic [5:0] seconds0,
    output logic [5:0] seconds1,
    output logic [5:0] minutes0,
    output logic       running,
    output logic       zero,
    output logic       done
);

    // Total seconds fits in 10 bits for any minutes digit up to 9 (599 s).
    localparam int          TW        = 10;
    localparam logic [3:0]  MAX_MIN_D = 4'(MAX_MIN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [3:0]      r_min;
    logic [3:0]      r_sec1;
    logic [3:0]      r_sec0;
    logic            r_running;
    logic            r_zero;
    logic            r_done;

    logic [3:0]      w_min_cl;
    logic [3:0]      w_sec1_cl;
    logic [3:0]      w_sec0_cl;
    logic [TW-1:0]   w_t_cur;
    logic [TW-1:0]   w_t_load;
    logic [TW-1:0]   w_t_sub;
    logic [TW-1:0]   w_t_next;
    logic [11:0]     w_next_digits;
    logic            w_decr;

    function automatic logic [TW-1:0] to_secs(input logic [3:0] m,
                                              input logic [3:0] s1,
                                              input logic [3:0] s0);
        return TW'(m) * TW'(60) + TW'(s1) * TW'(10) + TW'(s0);
    endfunction

    // Re-derive BCD digits {m, s1, s0} from a seconds total.
    function automatic logic [11:0] to_digits(input logic [TW-1:0] t);
        logic [3:0]    m;
        logic [TW-1:0] r;
        m = 4'(t / TW'(60));
        r = t - TW'(m) * TW'(60);
        return {m, 4'(r / TW'(10)), 4'(r % TW'(10))};
    endfunction

    assign w_min_cl  = (minutes0_in > MAX_MIN_D) ? MAX_MIN_D : minutes0_in;
    assign w_sec1_cl = (seconds1_in > 4'd5)      ? 4'd5      : seconds1_in;
    assign w_sec0_cl = (seconds0_in > 4'd9)      ? 4'd9      : seconds0_in;

    assign w_t_cur  = to_secs(r_min, r_sec1, r_sec0);
    assign w_t_load = to_secs(w_min_cl, w_sec1_cl, w_sec0_cl);
    assign w_t_sub  = TW'(subtractor);
    assign w_t_next = (w_t_cur > w_t_sub) ? (w_t_cur - w_t_sub) : '0;
    assign w_next_digits = to_digits(w_t_next);

    // A zero step is a no-op, including the ARMED->RUN move.
    assign w_decr = count && (subtractor != 6'd0) &&
                    ((r_state == S_ARMED) || (r_state == S_RUN));

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [TW-1:0] r_shadow_t;
    logic [11:0]   w_reload_digits;
    assign w_reload_digits = to_digits(r_shadow_t);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_min     <= 4'd0;
            r_sec1    <= 4'd0;
            r_sec0    <= 4'd0;
            r_running <= 1'b0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            r_shadow_t <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_min     <= w_min_cl;
                r_sec1    <= w_sec1_cl;
                r_sec0    <= w_sec0_cl;
                r_zero    <= (w_t_load == '0);
                r_running <= 1'b0;
                r_state   <= (w_t_load != '0) ? S_ARMED : S_IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
                r_shadow_t <= w_t_load;
`endif
            end else if (w_decr) begin
                if (w_t_next == '0) begin
                    r_done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    {r_min, r_sec1, r_sec0} <= w_reload_digits;
                    r_zero    <= (r_shadow_t == '0);
                    r_running <= 1'b1;
                    r_state   <= S_RUN;
`else
                    r_min     <= 4'd0;
                    r_sec1    <= 4'd0;
                    r_sec0    <= 4'd0;
                    r_zero    <= 1'b1;
                    r_running <= 1'b0;
                    r_state   <= S_DONE;
`endif
                end else begin
                    {r_min, r_sec1, r_sec0} <= w_next_digits;
                    r_zero    <= 1'b0;
                    r_running <= 1'b1;
                    r_state   <= S_RUN;
                end
            end
        end
    end

    assign minutes0 = {2'b00, r_min};
    assign seconds1 = {2'b00, r_sec1};
    assign seconds0 = {2'b00, r_sec0};
    assign running  = r_running;
    assign zero     = r_zero;
    assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
// Directed bench for countdown_timer. A seconds-level reference model tracks
// the remaining time and mode; one compare process checks every output at
// each falling clock edge, and directed steps pin the model with literal
// expected digits.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int MAX_MIN = 9;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       count = 1'b0;
    logic       load = 1'b0;
    logic [3:0] minutes0_in = 4'd0;
    logic [3:0] seconds1_in = 4'd0;
    logic [3:0] seconds0_in = 4'd0;
    logic [5:0] subtractor = 6'd0;
    logic [5:0] seconds0, seconds1, minutes0;
    logic       running, zero, done;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // reference model state
    int m_t    = 0;
    int m_last = 0;
    int m_mode = M_IDLE;
    int m_done = 0;

    countdown_timer #(.MAX_MIN(MAX_MIN)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .load        (load),
        .minutes0_in (minutes0_in),
        .seconds1_in (seconds1_in),
        .seconds0_in (seconds0_in),
        .subtractor  (subtractor),
        .seconds0    (seconds0),
        .seconds1    (seconds1),
        .minutes0    (minutes0),
        .running     (running),
        .zero        (zero),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge reset) begin
        int lt, nt;
        if (!reset) begin
            m_t = 0; m_last = 0; m_mode = M_IDLE; m_done = 0;
        end else begin
            m_done = 0;
            if (load) begin
                lt = 60 * clampi(int'(minutes0_in), MAX_MIN)
                   + 10 * clampi(int'(seconds1_in), 5)
                   + clampi(int'(seconds0_in), 9);
                m_t = lt;
                m_last = lt;
                m_mode = (lt > 0) ? M_ARMED : M_IDLE;
            end else if (count && subtractor != 0 &&
                         (m_mode == M_ARMED || m_mode == M_RUN)) begin
                nt = m_t - int'(subtractor);
                if (nt < 0) nt = 0;
                if (nt == 0) begin
                    m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    m_t = m_last;
                    m_mode = M_RUN;
`else
                    m_t = 0;
                    m_mode = M_DONE;
`endif
                end else begin
                    m_t = nt;
                    m_mode = M_RUN;
                end
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            cmp("minutes0", int'(minutes0), m_t / 60);
            cmp("seconds1", int'(seconds1), (m_t % 60) / 10);
            cmp("seconds0", int'(seconds0), m_t % 10);
            cmp("zero",     int'(zero),     (m_t == 0) ? 1 : 0);
            cmp("running",  int'(running),  (m_mode == M_RUN) ? 1 : 0);
            cmp("done",     int'(done),     m_done);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        cmp(name, act, exp);
    endtask

    task automatic chk_time(input string name, input int m, input int s1, input int s0);
        chk({name, ".m"},  int'(minutes0), m);
        chk({name, ".s1"}, int'(seconds1), s1);
        chk({name, ".s0"}, int'(seconds0), s0);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input int m, input int s1, input int s0);
        minutes0_in = 4'(m);
        seconds1_in = 4'(s1);
        seconds0_in = 4'(s0);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        bit seen;
        #12 reset = 1'b1;
        chk_en = 1'b1;
        chk_time("reset", 0, 0, 0);
        chk("reset.zero", int'(zero), 1);
        chk("reset.running", int'(running), 0);
        chk("reset.done", int'(done), 0);

        // load 1:05 and hold
        subtractor = 6'd1;
        do_load(1, 0, 5);
        chk_time("load105", 1, 0, 5);
        chk("load105.zero", int'(zero), 0);
        chk("load105.running", int'(running), 0);
        tick(10);
        chk_time("hold105", 1, 0, 5);

        // six single-second steps with borrow
        count = 1'b1;
        tick();
        chk_time("dec1", 1, 0, 4);
        chk("dec1.running", int'(running), 1);
        tick(5);
        chk_time("dec6", 0, 5, 9);
        count = 1'b0;

        // big step saturates to zero
        subtractor = 6'd15;
        do_load(0, 1, 0);
        count = 1'b1;
        tick();
`ifdef COUNTDOWN_AUTORELOAD_EN
        chk_time("sat", 0, 1, 0);
        chk("sat.done", int'(done), 1);
        chk("sat.running", int'(running), 1);
`else
        chk_time("sat", 0, 0, 0);
        chk("sat.zero", int'(zero), 1);
        chk("sat.done", int'(done), 1);
        chk("sat.running", int'(running), 0);
        tick();
        chk("sat.done2", int'(done), 0);
        tick(3);
        chk_time("sat.after", 0, 0, 0);
        chk("sat.done3", int'(done), 0);
`endif

        // load wins over simultaneous count
        subtractor = 6'd1;
        count = 1'b1;
        do_load(9, 5, 9);
        chk_time("ldcnt", 9, 5, 9);
        chk("ldcnt.running", int'(running), 0);
        count = 1'b0;

        // clamping
        do_load(12, 7, 11);
        chk_time("clamp", 9, 5, 9);
        do_load(4, 9, 3);
        chk_time("clamp_s1", 4, 5, 3);

        // asynchronous reset mid-run at 3:20
        do_load(3, 2, 5);
        count = 1'b1;
        tick(5);
        chk_time("run320", 3, 2, 0);
        #1 reset = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst.zero", int'(zero), 1);
        chk("async_rst.running", int'(running), 0);
        #2 reset = 1'b1;
        tick(3);
        chk_time("rst_idle", 0, 0, 0);
        count = 1'b0;

        // 5:00 in steps of 63 with a pause
        subtractor = 6'd63;
        do_load(5, 0, 0);
        count = 1'b1;
        tick(2);
        chk_time("s63", 2, 5, 4);
        count = 1'b0;
        tick(3);
        chk_time("pause", 2, 5, 4);
        chk("pause.running", int'(running), 1);
        count = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        count = 1'b0;

        // empty load returns to idle
        do_load(0, 0, 0);
        chk("ld0.zero", int'(zero), 1);
        chk("ld0.running", int'(running), 0);
        count = 1'b1;
        tick(2);
        chk_time("ld0.cnt", 0, 0, 0);
        count = 1'b0;

`ifdef COUNTDOWN_AUTORELOAD_EN
        subtractor = 6'd1;
        do_load(0, 0, 3);
        count = 1'b1;
        tick();
        chk_time("ar1", 0, 0, 2);
        tick();
        chk_time("ar2", 0, 0, 1);
        tick();
        chk_time("ar3", 0, 0, 3);
        chk("ar3.done", int'(done), 1);
        chk("ar3.running", int'(running), 1);
        tick();
        chk_time("ar4", 0, 0, 2);
        chk("ar4.done", int'(done), 0);
        count = 1'b0;
`endif

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting mm:ss timer, the inverse of the player's up-counting elapsed-time Timer. It is loaded with a start time in BCD digits and, while enabled, subtracts a programmable step from it each clock until it reaches 0:00. It then raises a one-cycle `done` pulse. The outputs use the same digit format as the Timer, so they feed the existing `driver7seg` instances directly. The block drives remaining-time display and end-of-track detection.

## Interface
- MAX_MIN, default 9: largest accepted minutes digit (0–9).
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- count  input  1  level enable; decrement allowed while high.
- load  input  1  one-cycle load strobe.
- minutes0_in  input  4  BCD minutes digit to load.
- seconds1_in  input  4  BCD tens-of-seconds digit to load.
- seconds0_in  input  4  BCD units-of-seconds digit to load.
- subtractor  input  6  seconds removed per enabled cycle, 0–63.
- seconds0  output  6  units-of-seconds digit; only [3:0] is meaningful; upper bits are 0.
- seconds1  output  6  tens-of-seconds digit, 0–5.
- minutes0  output  6  minutes digit, 0–MAX_MIN.
- running  output  1  high while in RUN.
- zero  output  1  high when the displayed time is 0:00.
- done  output  1  one-cycle pulse on expiry.

## Operation
- Time value: T = 60·minutes0 + 10·seconds1 + seconds0, range 0 to 60·MAX_MIN+59. All outputs are registered.
- Load clamping: each digit is clamped independently to its maximum before loading.
  - minutes0_in is clamped to MAX_MIN.
  - seconds1_in is clamped to 5.
  - seconds0_in is clamped to 9.
- Decrement: T_next = T − subtractor, saturating at 0. Digits are re-derived from T_next; they never hold non-BCD values.
- subtractor = 0: the value holds, no state change.
- State machine:
  - IDLE: reset state, value 0:00.
  - ARMED: value loaded, not yet counting.
  - RUN: counting.
  - DONE: expired, holding 0:00.
- Transitions:
  - Any state, load with clamped T > 0: go to ARMED. With clamped T = 0: go to IDLE.
  - ARMED & count: go to RUN and apply the first decrement on the same edge.
  - RUN & count & T_next > 0: stay in RUN.
  - RUN & count & T_next = 0: go to DONE and assert `done`.
  - RUN & !count: hold the value and stay in RUN. `running` stays high.
  - DONE: count is ignored; only load or reset leaves this state.
- Simultaneous load and count: load wins. No decrement occurs on that edge.
- `zero` = (T = 0), registered alongside the digits.

## Timing
- Reset values: all digits 0, running 0, done 0, zero 1, state IDLE. Reset takes effect immediately and asynchronously, including mid-count; the state returns to IDLE.
- Load latency: digits, zero and state update on the edge that samples load; they are visible 1 cycle later.
- Decrement latency: 1 cycle. The new value is visible after each edge on which count is sampled high in ARMED or RUN.
- `done`: high exactly one cycle, following the edge that transitions RUN→DONE. It never repeats without an intervening load.
- Throughput: one decrement per clock while count is high.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined:
  - On expiry the block reloads the last clamped load value, pulses `done`, and stays in RUN, so the next count decrements from the reloaded value.
  - DONE is unreachable.
  - The last load value is kept in a shadow register, cleared by reset.
- COUNTDOWN_AUTORELOAD_EN undefined:
  - Behaviour as described above: the block stops in DONE.
  - No shadow register is built.

## Test plan
- Reset, then load 1:05 with count=0 -> outputs 1,0,5; zero=0; running=0. Outputs hold for 10 cycles.
- From 1:05, subtractor=1, count=1 for 6 cycles -> 0:59 after the 6th cycle, showing the borrow across minutes and tens digits.
- Load 0:10, subtractor=15, count=1 -> one cycle later 0:00, zero=1, done pulses exactly one cycle, running=0. Further count high leaves everything unchanged.
- Load 9:59 at the same edge as count=1 -> 9:59 shown with no decrement. Load digits m=12, s1=7, s0=11 -> clamped to 9:59.
- Mid-run at 3:20, pulse reset low for 3 ns between clock edges -> outputs 0:00 and zero=1 immediately, state IDLE. Count high afterwards has no effect.
- With COUNTDOWN_AUTORELOAD_EN: load 0:03, subtractor=1, count=1 -> sequence 0:02, 0:01, 0:00→reload shows 0:03 with done pulse, then 0:02…; running stays 1.
